// File: rtl/event_encoder_8to3_pkg.sv
// rtl/event_encoder_8to3_pkg.sv - shared widths and FSM encoding for the 8-to-3 event encoder
package event_encoder_8to3_pkg;

  localparam int N_REQ  = 8;
  localparam int CODE_W = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/event_encoder_8to3_prio_enc8.sv
// rtl/event_encoder_8to3_prio_enc8.sv - combinational 8-bit priority encoder with one-hot of the winner
module prio_enc8
  import event_encoder_8to3_pkg::*;
#(
  parameter bit LOW_FIRST = 1'b1
) (
  input  logic [N_REQ-1:0]  req,
  output logic [CODE_W-1:0] idx,
  output logic              any,
  output logic [N_REQ-1:0]  onehot
);

  // Scan toward the highest-priority bit last so that it overrides the others.
  always_comb begin
    idx = '0;
    if (LOW_FIRST) begin
      for (int i = N_REQ - 1; i >= 0; i--) begin
        if (req[i]) idx = CODE_W'(i);
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (req[i]) idx = CODE_W'(i);
      end
    end
    any    = |req;
    onehot = any ? (N_REQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/event_encoder_8to3.sv
// rtl/event_encoder_8to3.sv - captures request events as pending bits and emits their indices over valid/ready
module event_encoder_8to3
  import event_encoder_8to3_pkg::*;
#(
  parameter bit EDGE_MODE = 1'b1,
  parameter bit LOW_FIRST = 1'b1
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              EN,
  input  logic [N_REQ-1:0]  REQ,
  input  logic              READY,
  output logic [CODE_W-1:0] CODE,
  output logic              VALID,
  output logic [N_REQ-1:0]  PEND,
  output logic              OVF
);

  state_e              state_q, state_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [N_REQ-1:0]    pend_q, pend_d;
  logic [N_REQ-1:0]    prev_q, prev_d;
  logic                ovf_q, ovf_d;
  logic [N_REQ-1:0]    new_ev;
  logic [N_REQ-1:0]    clr;
  logic                load;
  logic [CODE_W-1:0]   pend_idx;
  logic                pend_any;
  logic [N_REQ-1:0]    pend_onehot;

  prio_enc8 #(.LOW_FIRST(LOW_FIRST)) u_prio (
    .req    (pend_q),
    .idx    (pend_idx),
    .any    (pend_any),
    .onehot (pend_onehot)
  );

  always_comb begin
    new_ev = '0;
    if (EN) new_ev = EDGE_MODE ? (REQ & ~prev_q) : REQ;
    prev_d  = REQ;
    state_d = state_q;
    code_d  = code_q;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pend_any) begin
          load    = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (READY) begin
          if (pend_any) load = 1'b1;
          else          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (load) code_d = pend_idx;
    // A fresh event on the bit being loaded re-sets it, counting as a second event.
    clr    = load ? pend_onehot : '0;
    pend_d = (pend_q & ~clr) | new_ev;
    ovf_d  = ovf_q | (|(new_ev & pend_q & ~clr));
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q <= ST_IDLE;
      code_q  <= '0;
      pend_q  <= '0;
      prev_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      pend_q  <= pend_d;
      prev_q  <= prev_d;
      ovf_q   <= ovf_d;
    end
  end

  assign CODE  = code_q;
  assign VALID = (state_q == ST_HOLD);
  assign PEND  = pend_q;
  assign OVF   = ovf_q;

endmodule

// File: tb/tb_event_encoder_8to3.sv
// tb/tb_event_encoder_8to3.sv - scoreboard bench for both priority orders against a set-based reference model
module tb_event_encoder_8to3;

  logic       Clock = 1'b0;
  logic       Resetn = 1'b0;
  logic       EN = 1'b0;
  logic       READY = 1'b0;
  logic [7:0] REQ = 8'h00;

  logic [2:0] code_lo, code_hi;
  logic       valid_lo, valid_hi;
  logic [7:0] pend_lo, pend_hi;
  logic       ovf_lo, ovf_hi;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: index 0 models LOW_FIRST=1, index 1 models LOW_FIRST=0.
  bit m_pend [2][8];
  int m_pres [2];
  int m_last [2];
  bit m_ovf  [2];
  bit m_prev [8];
  bit have_state = 1'b0;
  int exp_lo[$];
  int exp_hi[$];

  always #5 Clock = ~Clock;

  event_encoder_8to3 #(.EDGE_MODE(1'b1), .LOW_FIRST(1'b1)) u_lo (
    .Clock(Clock), .Resetn(Resetn), .EN(EN), .REQ(REQ), .READY(READY),
    .CODE(code_lo), .VALID(valid_lo), .PEND(pend_lo), .OVF(ovf_lo)
  );

  event_encoder_8to3 #(.EDGE_MODE(1'b1), .LOW_FIRST(1'b0)) u_hi (
    .Clock(Clock), .Resetn(Resetn), .EN(EN), .REQ(REQ), .READY(READY),
    .CODE(code_hi), .VALID(valid_hi), .PEND(pend_hi), .OVF(ovf_hi)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int best(input int d);
    if (d == 0) begin
      for (int i = 0; i < 8; i++) if (m_pend[d][i]) return i;
    end else begin
      for (int i = 7; i >= 0; i--) if (m_pend[d][i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 8; i++) m_pend[d][i] = 1'b0;
      m_pres[d] = -1;
      m_last[d] = 0;
      m_ovf[d]  = 1'b0;
    end
    for (int i = 0; i < 8; i++) m_prev[i] = 1'b0;
    exp_lo.delete();
    exp_hi.delete();
    have_state = 1'b1;
  endtask

  task automatic model_step();
    bit newv [8];
    for (int i = 0; i < 8; i++) newv[i] = EN && REQ[i] && !m_prev[i];
    for (int d = 0; d < 2; d++) begin
      int pick;
      bit take;
      pick = -1;
      take = (m_pres[d] < 0) || READY;
      if (take) pick = best(d);
      for (int i = 0; i < 8; i++)
        if (newv[i] && m_pend[d][i] && i != pick) m_ovf[d] = 1'b1;
      if (take) begin
        if (pick >= 0) begin
          m_pres[d] = pick;
          m_last[d] = pick;
          if (d == 0) exp_lo.push_back(pick);
          else        exp_hi.push_back(pick);
          m_pend[d][pick] = 1'b0;
        end else begin
          m_pres[d] = -1;
        end
      end
      for (int i = 0; i < 8; i++) if (newv[i]) m_pend[d][i] = 1'b1;
    end
    for (int i = 0; i < 8; i++) m_prev[i] = REQ[i];
  endtask

  task automatic check_state();
    logic [7:0] p0, p1;
    for (int i = 0; i < 8; i++) begin
      p0[i] = m_pend[0][i];
      p1[i] = m_pend[1][i];
    end
    chk("lo_valid", int'(valid_lo), int'(m_pres[0] >= 0));
    chk("lo_pend",  int'(pend_lo),  int'(p0));
    chk("lo_ovf",   int'(ovf_lo),   int'(m_ovf[0]));
    chk("lo_code",  int'(code_lo),  m_last[0]);
    chk("hi_valid", int'(valid_hi), int'(m_pres[1] >= 0));
    chk("hi_pend",  int'(pend_hi),  int'(p1));
    chk("hi_ovf",   int'(ovf_hi),   int'(m_ovf[1]));
    chk("hi_code",  int'(code_hi),  m_last[1]);
  endtask

  task automatic cyc(input bit rstn, input bit en, input logic [7:0] req, input bit rdy);
    @(posedge Clock);
    #1;
    if (have_state) check_state();
    Resetn = rstn;
    EN     = en;
    REQ    = req;
    READY  = rdy;
    if (!rstn) model_reset();
    else       model_step();
  endtask

  always @(negedge Clock) begin
    int e;
    if (Resetn === 1'b1 && valid_lo === 1'b1 && READY === 1'b1) begin
      if (exp_lo.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL lo_scoreboard: got code %0d expected no output", code_lo);
      end else begin
        e = exp_lo.pop_front();
        chk("lo_sb_code", int'(code_lo), e);
      end
    end
  end

  always @(negedge Clock) begin
    int e;
    if (Resetn === 1'b1 && valid_hi === 1'b1 && READY === 1'b1) begin
      if (exp_hi.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL hi_scoreboard: got code %0d expected no output", code_hi);
      end else begin
        e = exp_hi.pop_front();
        chk("hi_sb_code", int'(code_hi), e);
      end
    end
  end

  initial begin
    // reset with all requests high, released with requests low
    repeat (2) cyc(1'b0, 1'b1, 8'hFF, 1'b1);
    repeat (4) cyc(1'b1, 1'b1, 8'h00, 1'b1);
    // single edge held high
    repeat (6) cyc(1'b1, 1'b1, 8'h20, 1'b1);
    cyc(1'b1, 1'b1, 8'h00, 1'b1);
    // burst
    cyc(1'b1, 1'b1, 8'hA5, 1'b1);
    repeat (7) cyc(1'b1, 1'b1, 8'h00, 1'b1);
    // backpressure
    repeat (6) cyc(1'b1, 1'b1, 8'h06, 1'b0);
    repeat (4) cyc(1'b1, 1'b1, 8'h06, 1'b1);
    cyc(1'b1, 1'b1, 8'h00, 1'b1);
    // overflow on bit 3
    cyc(1'b1, 1'b1, 8'h02, 1'b0);
    cyc(1'b1, 1'b1, 8'h0A, 1'b0);
    cyc(1'b1, 1'b1, 8'h02, 1'b0);
    cyc(1'b1, 1'b1, 8'h0A, 1'b0);
    repeat (5) cyc(1'b1, 1'b1, 8'h00, 1'b1);
    // set-wins: new edge on bit 3 at the edge that loads it
    cyc(1'b1, 1'b1, 8'h0A, 1'b0);
    cyc(1'b1, 1'b1, 8'h0A, 1'b0);
    cyc(1'b1, 1'b1, 8'h02, 1'b0);
    cyc(1'b1, 1'b1, 8'h0A, 1'b1);
    repeat (5) cyc(1'b1, 1'b1, 8'h00, 1'b1);
    // EN gating: edge while disabled is lost
    cyc(1'b1, 1'b0, 8'h00, 1'b1);
    cyc(1'b1, 1'b0, 8'h10, 1'b1);
    repeat (4) cyc(1'b1, 1'b1, 8'h10, 1'b1);
    cyc(1'b1, 1'b1, 8'h00, 1'b1);
    // EN low while events pending: they still drain
    cyc(1'b1, 1'b1, 8'h03, 1'b0);
    cyc(1'b1, 1'b0, 8'h03, 1'b0);
    repeat (5) cyc(1'b1, 1'b0, 8'h00, 1'b1);
    // randomized traffic with occasional resets
    for (int k = 0; k < 3000; k++) begin
      cyc(($urandom_range(0, 199) != 0), ($urandom_range(0, 7) != 0),
          8'($urandom & $urandom), ($urandom_range(0, 3) != 0));
    end
    repeat (12) cyc(1'b1, 1'b1, 8'h00, 1'b1);
    @(posedge Clock);
    #1;
    check_state();
    chk("lo_queue_empty", exp_lo.size(), 0);
    chk("hi_queue_empty", exp_hi.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
